// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int DROP_W = 8;
  localparam int MAX_CH = 16;

  typedef enum logic {
    ROUTE_SEL = 1'b0,
    ROUTE_RR  = 1'b1
  } route_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_stream_1_n_if.sv
// Input beat handshake, per-channel output bus and drop counter of the demux.
interface demux_stream_1_n_if
  import demux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);

  logic [W-1:0]      d;
  logic              d_valid;
  logic              d_ready;
  logic [SW-1:0]     s;
  logic              rr_en;
  logic [N*W-1:0]    y;
  logic [N-1:0]      y_valid;
  logic [N-1:0]      y_ready;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output d, d_valid, s, rr_en, y_ready,
    input  d_ready, y, y_valid, drop_cnt
  );

  modport slave (
    input  d, d_valid, s, rr_en, y_ready,
    output d_ready, y, y_valid, drop_cnt
  );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register for a single channel: load wins over drain.
module demux_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      // Covers the simultaneous drain+load case: the slot stays full.
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_stream_1_n.sv
// 1-to-N stream demux: select or round-robin routing into per-channel slots,
// beats aimed past the last channel are dropped and counted.
module demux_stream_1_n
  import demux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input logic               clk,
  input logic               rst,
  demux_stream_1_n_if.slave bus
);

  if (N < 2 || N > MAX_CH) begin : g_bad_n
    $error("demux_stream_1_n: N out of range");
  end

  route_e             mode;
  logic [SW-1:0]      tgt;
  logic               drop;
  logic               ch_ready;
  logic               accept;
  logic [N-1:0]       load;
  logic [N-1:0]       y_valid_w;
  logic [N-1:0][W-1:0] y_w;

  logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Ready never looks at d_valid, only at where the beat would land.
  always_comb begin
    mode     = route_e'(bus.rr_en);
    tgt      = (mode == ROUTE_RR) ? rr_ptr_q : bus.s;
    drop     = (mode == ROUTE_SEL) && (int'(bus.s) >= N);
    ch_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (tgt == SW'(k)) ch_ready = !y_valid_w[k] || bus.y_ready[k];
    end
    bus.d_ready = !rst && (drop || ch_ready);
    accept      = bus.d_valid && bus.d_ready;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && !drop && (tgt == SW'(k));
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (accept && mode == ROUTE_RR) begin
      rr_ptr_d = (rr_ptr_q == SW'(N - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
    if (accept && drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_out_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .drain_i (bus.y_ready[k]),
      .data_i  (bus.d),
      .valid_o (y_valid_w[k]),
      .data_o  (y_w[k])
    );
  end

  assign bus.y        = y_w;
  assign bus.y_valid  = y_valid_w;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Directed bench for demux_stream_1_n with a per-channel expected-data scoreboard.
module tb_demux_stream_1_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_stream_1_n_if #(.N(4), .W(8)) bus4 ();
  demux_stream_1_n_if #(.N(3), .W(8)) bus3 ();

  demux_stream_1_n #(.N(4), .W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  demux_stream_1_n #(.N(3), .W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q [4][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every beat leaving a channel must match the oldest one routed there.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (bus4.y_valid[k] && bus4.y_ready[k]) begin
          chk($sformatf("sb_nonempty_ch%0d", k), 64'(exp_q[k].size() != 0), 1);
          if (exp_q[k].size() != 0) chk($sformatf("sb_data_ch%0d", k), bus4.y[k*8 +: 8], exp_q[k].pop_front());
        end
      end
    end
  end

  // Entry and exit just after a rising edge; one accept, then a latency check.
  task automatic beat(input logic [7:0] dat, input logic [1:0] sel, input logic rr, input int ch);
    bus4.d = dat; bus4.s = sel; bus4.rr_en = rr; bus4.d_valid = 1'b1;
    @(negedge clk); chk($sformatf("d_ready_%0h", dat), bus4.d_ready, 1);
    @(posedge clk); exp_q[ch].push_back(dat);
    #1 bus4.d_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("lat_valid_%0h", dat), bus4.y_valid[ch], 1);
    chk($sformatf("lat_data_%0h", dat), bus4.y[ch*8 +: 8], dat);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus4.d = 8'h5A; bus4.d_valid = 1'b1; bus4.s = 2'd0; bus4.rr_en = 1'b0; bus4.y_ready = 4'hF;
    bus3.d = 8'h00; bus3.d_valid = 1'b0; bus3.s = 2'd0; bus3.rr_en = 1'b0; bus3.y_ready = 3'h7;

    // Reset: nothing accepted, everything cleared
    @(negedge clk); chk("rst_d_ready", bus4.d_ready, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; bus4.d_valid = 1'b0;
    @(negedge clk);
    chk("rst_y_valid", bus4.y_valid, 0);
    chk("rst_y", bus4.y, 0);
    chk("rst_drop", bus4.drop_cnt, 0);
    chk("rst_y_valid3", bus3.y_valid, 0);
    @(posedge clk); #1;

    // Select routing
    for (int k = 0; k < 4; k++) beat(8'h10 + 8'(k), 2'(k), 1'b0, k);

    // Backpressure on channel 2
    bus4.y_ready = 4'b1011;
    beat(8'hA1, 2'd2, 1'b0, 2);
    bus4.d = 8'hA2; bus4.s = 2'd2; bus4.d_valid = 1'b1;
    @(negedge clk); chk("bp_d_ready0", bus4.d_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_d_ready1", bus4.d_ready, 0);
    chk("bp_hold_valid", bus4.y_valid[2], 1);
    chk("bp_hold_data", bus4.y[23:16], 8'hA1);
    @(posedge clk); #1 bus4.y_ready = 4'hF;
    @(negedge clk); chk("bp_release_ready", bus4.d_ready, 1);
    @(posedge clk); exp_q[2].push_back(8'hA2);
    #1 bus4.d_valid = 1'b0;
    @(negedge clk);
    chk("bp_swap_valid", bus4.y_valid[2], 1);
    chk("bp_swap_data", bus4.y[23:16], 8'hA2);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_drained", bus4.y_valid[2], 0);
    @(posedge clk); #1;

    // Round-robin with a stall that must not advance the pointer
    for (int i = 0; i < 3; i++) beat(8'(i), 2'd3, 1'b1, i);
    bus4.rr_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 3; i < 6; i++) beat(8'(i), 2'd3, 1'b1, i % 4);

    // Mode switching: select leaves the pointer (now 2) alone
    beat(8'h55, 2'd0, 1'b0, 0);
    beat(8'h66, 2'd1, 1'b1, 2);
    chk("sb_empty_mid", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 0);

    // Mid-stream reset with channels 1 and 3 full
    bus4.y_ready = 4'b0101;
    beat(8'hB1, 2'd1, 1'b0, 1);
    beat(8'hB3, 2'd3, 1'b0, 3);
    rst = 1'b1; bus4.d = 8'hEE; bus4.d_valid = 1'b1; bus4.rr_en = 1'b1;
    @(negedge clk); chk("mrst_d_ready", bus4.d_ready, 0);
    @(posedge clk); #1 rst = 1'b0; bus4.d_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    chk("mrst_y_valid", bus4.y_valid, 0);
    chk("mrst_y", bus4.y, 0);
    chk("mrst_drop", bus4.drop_cnt, 0);
    @(posedge clk); #1 bus4.y_ready = 4'hF;
    beat(8'hC0, 2'd2, 1'b1, 0);

    // Drop path on the 3-channel instance
    bus3.s = 2'd3; bus3.rr_en = 1'b0; bus3.d = 8'h77; bus3.d_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk($sformatf("drop_ready_%0d", i), bus3.d_ready, 1);
      chk($sformatf("drop_novalid_%0d", i), bus3.y_valid, 0);
      if (i == 0 || i == 100 || i == 254 || i == 255 || i == 299)
        chk($sformatf("drop_cnt_%0d", i), bus3.drop_cnt, (i > 255) ? 255 : i);
      @(posedge clk); #1;
    end
    bus3.d_valid = 1'b0;
    @(negedge clk); chk("drop_cnt_final", bus3.drop_cnt, 255);
    chk("sb_empty_end", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_stream_1_n.md
DEMUX_STREAM_1_N -- requirements
Module: demux_stream_1_n

Interface
REQ-001 Parameter N, default 4, number of output channels (2..16).
REQ-002 Parameter W, default 8, data width in bits (1..64).
REQ-003 Parameter SW, default $clog2(N), select width; it SHALL NOT be overridden.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 d  input  W  input data beat.
REQ-007 d_valid  input  1  input beat valid.
REQ-008 d_ready  output  1  input beat accepted when d_valid & d_ready.
REQ-009 s  input  SW  destination channel select.
REQ-010 rr_en  input  1  1 = round-robin routing, with s ignored; 0 = select routing.
REQ-011 y  output  N*W  channel data, channel k at bits [k*W +: W].
REQ-012 y_valid  output  N  per-channel valid.
REQ-013 y_ready  input  N  per-channel downstream ready.
REQ-014 drop_cnt  output  8  saturating count of beats dropped because s >= N.

Function
REQ-015 Each channel SHALL hold a one-entry output register (data plus valid flag); y and y_valid SHALL be driven from these registers only.
REQ-016 Target channel t SHALL be s when rr_en=0, and rr_ptr when rr_en=1.
REQ-017 d_ready SHALL be 1 when t >= N (drop case), or when y_valid[t]=0, or when y_ready[t]=1; otherwise d_ready SHALL be 0.
REQ-018 On an accept with t < N, channel t's register SHALL load d and set valid, giving exactly 1 cycle latency from accept to y_valid[t].
REQ-019 A channel holding valid with y_ready=1 and no new load SHALL clear valid on the next edge.
REQ-020 A simultaneous drain and load on the same channel SHALL leave valid=1 with the new data, giving full throughput of one beat per cycle.
REQ-021 A non-target channel SHALL hold its data and valid unchanged while y_ready=0.
REQ-022 On an accept with t >= N (select mode only), the beat SHALL be discarded, no channel SHALL change, and drop_cnt SHALL increment, saturating at 255.
REQ-023 rr_ptr SHALL advance only on an accepted beat in round-robin mode, with wrap-around N-1 -> 0; it SHALL hold otherwise, including in select mode.
REQ-024 Changing rr_en between cycles SHALL take effect on the next cycle without corrupting held channel data.
REQ-025 d_ready SHALL be combinational from s, rr_en, rr_ptr, y_valid and y_ready; there SHALL be no path from d_valid to d_ready.
REQ-026 y_valid[k] SHALL NOT drop while y_ready[k]=0, and y[k] SHALL stay stable while valid and stalled.

Reset
REQ-027 On rst=1 at a clock edge, all y_valid, rr_ptr and drop_cnt SHALL become 0, and y SHALL become all zeros.
REQ-028 During reset, d_ready SHALL be forced to 0 and no beat SHALL be accepted.
REQ-029 A reset asserted mid-stream SHALL discard all held beats; the first accept after reset in round-robin mode SHALL target channel 0.

Structure
REQ-030 A shared package demux_pkg SHALL hold the drop counter width (8) and the channel-limit constant (16).
REQ-031 The one-entry register SHALL be a sub-module demux_out_slot (W-wide, with load, drain and valid), instantiated N times via generate.
REQ-032 Routing, rr_ptr and drop_cnt SHALL reside in the top module.

Verification (N=4, W=8)
REQ-033 Select routing: rr_en=0, all y_ready=1, send s=0..3 with d=0x10..0x13 -> y_valid[k] with y[k]=0x10+k exactly one cycle after each accept.
REQ-034 Backpressure: y_ready[2]=0, send two beats to s=2 (0xA1, 0xA2) -> first held, d_ready=0 on second until y_ready[2]=1; then 0xA2 loads in the same cycle 0xA1 drains.
REQ-035 Round-robin: rr_en=1, 6 accepted beats 0x00..0x05 -> channels 0,1,2,3,0,1; a stall cycle with d_valid=0 SHALL NOT advance rr_ptr.
REQ-036 Drop: N=3, s=3, 300 beats -> d_ready=1 throughout, no y_valid, drop_cnt=255.
REQ-037 Reset mid-operation: channels 1 and 3 valid, rst=1 for one cycle -> all y_valid=0, drop_cnt=0, and the next round-robin beat goes to channel 0.
